multicycle_control: RTL

Moore-style finite state machine that sequences the multicycle CPU. It sits directly upstream of `Datapath`: it consumes the 6-bit `Opcode` that `Datapath` produces and drives every `Datapath` control input (`ALUOp`, mux selects, write enables) one state per clock. Replaces hand-driven stimulus in datapath benches and forms the CPU top with `Datapath`.

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/control_out_decode.sv | 79 +++++++
 rtl/multicycle_control.sv | 90 +++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle CPU controller: states, opcode classes, select codes.
// CTRL_ILLEGAL_TRAP_EN adds the HALT state used to trap illegal opcode classes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StAddr,
        StMemRd,
        StWbAlu,
        StWbMem,
        StStore,
        StBranch,
        StJump
`ifdef CTRL_ILLEGAL_TRAP_EN
        , StHalt
`endif
    } state_e;

    localparam int unsigned STATE_W = 4;

    // Opcode[5:3] instruction classes
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ITYPE = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       instr_done;
        logic       halted;
    } ctrl_out_t;

    localparam int unsigned CTRL_W = $bits(ctrl_out_t);

    function automatic logic op_is_legal(input logic [2:0] cls);
        return (cls <= OP_J);
    endfunction

endpackage

// File: rtl/control_out_decode.sv
// Moore output decode: state (plus ALU function bits in EXEC states) -> datapath controls.
// halted can only assert when CTRL_ILLEGAL_TRAP_EN builds the HALT state.
module control_out_decode
    import ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [2:0]         alu_func,
    output logic [CTRL_W-1:0]  ctrl
);

    ctrl_out_t o;

    always_comb begin
        o = '0;
        case (state_e'(state))
            StFetch: begin
                o.alu_op    = ALU_ADD;
                o.alu_src_b = SRCB_ONE;
                o.pc_write  = 1'b1;
                o.ir_write  = 1'b1;
            end
            // branch target computed early so BRANCH only needs the compare
            StDecode: begin
                o.alu_op    = ALU_ADD;
                o.alu_src_b = SRCB_IMM;
            end
            StExecR: begin
                o.alu_op    = alu_func;
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_REG;
            end
            StExecI: begin
                o.alu_op    = alu_func;
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_IMM;
            end
            StAddr: begin
                o.alu_op    = ALU_ADD;
                o.alu_src_a = 1'b1;
                o.alu_src_b = SRCB_IMM;
            end
            StWbAlu: begin
                o.reg_write  = 1'b1;
                o.instr_done = 1'b1;
            end
            StWbMem: begin
                o.mem_to_reg = 1'b1;
                o.reg_write  = 1'b1;
                o.instr_done = 1'b1;
            end
            StStore: begin
                o.mem_write  = 1'b1;
                o.instr_done = 1'b1;
            end
            StBranch: begin
                o.alu_op        = ALU_SUB;
                o.alu_src_a     = 1'b1;
                o.alu_src_b     = SRCB_REG;
                o.pc_source     = PCSRC_ALUOUT;
                o.pc_write_cond = 1'b1;
                o.instr_done    = 1'b1;
            end
            StJump: begin
                o.pc_write   = 1'b1;
                o.pc_source  = PCSRC_JUMP;
                o.instr_done = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            StHalt: begin
                o.halted = 1'b1;
            end
`endif
            default: ; // IDLE, MEM_RD: everything low
        endcase
    end

    assign ctrl = o;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: state register and opcode dispatch feeding control_out_decode.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcode classes instead of treating them as NOP.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    output logic [2:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       MemToReg,
    output logic [1:0] PCSource,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       halted
);

    state_e state_q, state_d;
    // Holds IDLE through the first edge after reset release so FETCH lands on the second edge.
    logic   armed_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (armed_q) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (Opcode[5:3])
                    OP_RTYPE:     state_d = StExecR;
                    OP_ITYPE:     state_d = StExecI;
                    OP_LW, OP_SW: state_d = StAddr;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = StHalt;
`else
                    default:      state_d = StFetch;
`endif
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            StAddr:   state_d = (Opcode[5:3] == OP_LW) ? StMemRd : StStore;
            StMemRd:  state_d = StWbMem;
            StWbAlu, StWbMem, StStore, StBranch, StJump: state_d = StFetch;
`ifdef CTRL_ILLEGAL_TRAP_EN
            StHalt:   state_d = StHalt;
`endif
            default:  state_d = StIdle;
        endcase
    end

    logic [CTRL_W-1:0] ctrl_vec;
    ctrl_out_t         ctrl;

    control_out_decode u_decode (
        .state    (state_q),
        .alu_func (Opcode[2:0]),
        .ctrl     (ctrl_vec)
    );

    assign ctrl        = ctrl_out_t'(ctrl_vec);
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign MemToReg    = ctrl.mem_to_reg;
    assign PCSource    = ctrl.pc_source;
    assign IRWrite     = ctrl.ir_write;
    assign MemWrite    = ctrl.mem_write;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign RegWrite    = ctrl.reg_write;
    assign instr_done  = ctrl.instr_done;
    assign halted      = ctrl.halted;

endmodule
